counter_4bit_2clock: RTL and testbench

// - Free-running binary up-counter, 4 bits by default, one clock domain per instance.
// - Used in pairs, each instance on its own unrelated clock, to exercise multi-clock

---
 rtl/counter_pkg.sv | 18 +
 rtl/counter_4bit_2clock_if.sv | 9 +
 rtl/counter_core.sv | 49 ++++
 rtl/counter_4bit_2clock.sv | 31 +++
 tb/tb_counter_4bit_2clock.sv | 114 +++++++++++
 5 files changed

// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared counter helpers: default terminal count and parameter legality
package counter_pkg;

    function automatic longint default_max(input int width);
        return (longint'(1) << width) - 1;
    endfunction

    function automatic bit width_ok(input int width);
        return (width >= 1) && (width <= 32);
    endfunction

    function automatic bit params_ok(input int width, input longint rst_val,
                                     input longint step, input longint max_val);
        return width_ok(width) && (rst_val >= 0) && (rst_val <= max_val)
            && (max_val < (longint'(1) << width)) && (step != 0);
    endfunction

endpackage

// File: rtl/counter_4bit_2clock_if.sv
// rtl/counter_4bit_2clock_if.sv - count bus between counter core and its consumer
interface counter_4bit_2clock_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] cnt_o;

    modport master (output cnt_o);
    modport slave  (input  cnt_o);
endinterface

// File: rtl/counter_core.sv
// rtl/counter_core.sv - parameterized count register with step, wrap compare and reset mux
module counter_core
    import counter_pkg::*;
#(
    parameter int     WIDTH   = 4,
    parameter longint RST_VAL = 0,
    parameter longint STEP    = 1,
    parameter longint MAX_VAL = default_max(WIDTH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    counter_4bit_2clock_if.master   cnt_if
);

    generate
        if (!params_ok(WIDTH, RST_VAL, STEP, MAX_VAL)) begin : g_bad_params
            $fatal(1, "counter_core: illegal WIDTH/RST_VAL/STEP/MAX_VAL combination");
        end
    endgenerate

    // One extra bit so q + STEP never aliases below MAX_VAL.
    localparam logic [WIDTH:0]   STEP_W = STEP[WIDTH:0];
    localparam logic [WIDTH:0]   MAX_W  = MAX_VAL[WIDTH:0];
    localparam logic [WIDTH-1:0] RST_W  = RST_VAL[WIDTH-1:0];

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] nxt;
    logic [WIDTH:0]   sum;

    assign sum = {1'b0, cnt} + STEP_W;

    always_comb begin
        nxt = sum[WIDTH-1:0];
        if (({1'b0, cnt} == MAX_W) || (sum > MAX_W)) begin
            nxt = RST_W;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= RST_W;
        end else begin
            cnt <= nxt;
        end
    end

    assign cnt_if.cnt_o = cnt;

endmodule

// File: rtl/counter_4bit_2clock.sv
// rtl/counter_4bit_2clock.sv - free-running up-counter, one clock domain, flow-facing ports
module counter_4bit_2clock
    import counter_pkg::*;
#(
    parameter int     WIDTH   = 4,
    parameter longint RST_VAL = 0,
    parameter longint STEP    = 1,
    parameter longint MAX_VAL = default_max(WIDTH)
) (
    input  logic             clk,
    output logic [WIDTH-1:0] q,
    input  logic             rst
);

    counter_4bit_2clock_if #(.WIDTH(WIDTH)) cnt_if ();

    // rst is active-low and feeds the register directly, without a synchronizer.
    counter_core #(
        .WIDTH   (WIDTH),
        .RST_VAL (RST_VAL),
        .STEP    (STEP),
        .MAX_VAL (MAX_VAL)
    ) u_core (
        .clk    (clk),
        .rst_n  (rst),
        .cnt_if (cnt_if.master)
    );

    assign q = cnt_if.cnt_o;

endmodule

// File: tb/tb_counter_4bit_2clock.sv
// tb/tb_counter_4bit_2clock.sv - self-checking bench: two clock domains plus a step-3 variant
module tb_counter_4bit_2clock;

    logic clk_a = 1'b0;
    logic clk_b = 1'b0;
    logic rst_a;
    logic rst_b;
    logic rst_c;

    int total = 0;
    int bad   = 0;

    int n_a = 0;
    int n_b = 0;
    int n_c = 0;

    counter_4bit_2clock_if #(.WIDTH(4)) bus_a ();
    counter_4bit_2clock_if #(.WIDTH(4)) bus_b ();
    counter_4bit_2clock_if #(.WIDTH(3)) bus_c ();

    counter_4bit_2clock dut_a (.clk(clk_a), .q(bus_a.cnt_o), .rst(rst_a));
    counter_4bit_2clock dut_b (.clk(clk_b), .q(bus_b.cnt_o), .rst(rst_b));
    counter_4bit_2clock #(.WIDTH(3), .STEP(3), .MAX_VAL(7))
        dut_c (.clk(clk_a), .q(bus_c.cnt_o), .rst(rst_c));

    initial forever #10 clk_a = ~clk_a;
    initial begin
        #5;
        forever #20 clk_b = ~clk_b;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: rising edges seen since the last reset release.
    always @(posedge clk_a or negedge rst_a) if (!rst_a) n_a = 0; else n_a = n_a + 1;
    always @(posedge clk_b or negedge rst_b) if (!rst_b) n_b = 0; else n_b = n_b + 1;
    always @(posedge clk_a or negedge rst_c) if (!rst_c) n_c = 0; else n_c = n_c + 1;

    always @(negedge clk_a) begin
        check("model_a", {28'd0, bus_a.cnt_o}, n_a % 16);
        check("model_c", {29'd0, bus_c.cnt_o}, (n_c % 3) * 3);
    end

    always @(negedge clk_b) begin
        check("model_b", {28'd0, bus_b.cnt_o}, n_b % 16);
    end

    logic [2:0] c_lit [0:5];
    int         hist  [16];
    bit         found;

    initial begin
        c_lit = '{3'd3, 3'd6, 3'd0, 3'd3, 3'd6, 3'd0};
        foreach (hist[v]) hist[v] = 0;
        rst_a = 1'b0;
        rst_b = 1'b0;
        rst_c = 1'b0;
        #1;
        check("reset_a", {28'd0, bus_a.cnt_o}, 0);
        check("reset_b", {28'd0, bus_b.cnt_o}, 0);
        #99;
        rst_a = 1'b1;
        rst_b = 1'b1;
        rst_c = 1'b1;

        for (int i = 1; i <= 15; i++) begin
            @(posedge clk_a);
            #1;
            if (i == 5) check("five_edges", {28'd0, bus_a.cnt_o}, 5);
            if (i <= 6) check("step3_seq", {29'd0, bus_c.cnt_o}, {29'd0, c_lit[i-1]});
        end
        check("fifteen_edges", {28'd0, bus_a.cnt_o}, 15);
        @(posedge clk_a);
        #1;
        check("wrap", {28'd0, bus_a.cnt_o}, 0);

        for (int i = 0; i < 32; i++) begin
            @(posedge clk_a);
            #1;
            hist[bus_a.cnt_o]++;
        end
        for (int v = 0; v < 16; v++) check("hist_twice", hist[v], 2);

        #(5000 - $time);
        check("indep_a_5000", {28'd0, bus_a.cnt_o}, 5);
        check("indep_b_5000", {28'd0, bus_b.cnt_o}, 11);

        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            @(posedge clk_a);
            #1;
            if (bus_a.cnt_o == 4'd9) found = 1'b1;
        end
        check("reach_nine", {31'd0, found}, 1);
        #4 rst_a = 1'b0;
        #1 check("async_reset", {28'd0, bus_a.cnt_o}, 0);
        #4 rst_a = 1'b1;
        @(posedge clk_a);
        #1;
        check("restart_one", {28'd0, bus_a.cnt_o}, 1);

        repeat (20) @(posedge clk_a);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
